// File: rtl/bert_pkg.sv
// bert_pkg: PRBS13 constants shared by the BERT generator and checker,
// plus the checker state encoding.
package bert_pkg;

    localparam int PRBS_W = 13;

    // Feedback taps {12,3,2,0}
    localparam logic [PRBS_W-1:0] PRBS_TAPS = 13'h100D;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        VERIFY,
        LOCKED
    } chk_state_t;

    function automatic logic prbs_fb(input logic [PRBS_W-1:0] s);
        return ^(s & PRBS_TAPS);
    endfunction

endpackage

// File: rtl/prbs13_checker_sat_counter.sv
// sat_counter: counter that sticks at all-ones; clear beats increment.
// Used for the host-visible bit and error totals.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prbs13_checker.sv
// prbs13_checker: self-synchronising PRBS13 receive checker with lock
// tracking, per-bit error pulse and saturating bit/error totals.
module prbs13_checker
    import bert_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int VERIFY_LEN  = 13,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int FW = $clog2(PRBS_W + 1);
    localparam int VW = $clog2(VERIFY_LEN + 1);
    localparam int WW = $clog2(LOSS_WINDOW);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    chk_state_t        state, state_n;
    logic [PRBS_W-1:0] sr, sr_n;
    logic [FW-1:0]     fill, fill_n;
    logic [VW-1:0]     vcnt, vcnt_n;
    logic [WW-1:0]     wcnt, wcnt_n;
    logic [EW-1:0]     werr, werr_n, werr_inc;
    logic              pred, mism;
    logic              error_n, bit_inc, err_inc;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            sr    <= '0;
            fill  <= '0;
            vcnt  <= '0;
            wcnt  <= '0;
            werr  <= '0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            fill  <= fill_n;
            vcnt  <= vcnt_n;
            wcnt  <= wcnt_n;
            werr  <= werr_n;
            error <= error_n;
        end
    end

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        fill_n   = fill;
        vcnt_n   = vcnt;
        wcnt_n   = wcnt;
        werr_n   = werr;
        error_n  = 1'b0;
        bit_inc  = 1'b0;
        err_inc  = 1'b0;
        pred     = prbs_fb(sr);
        mism     = din ^ pred;
        werr_inc = werr + EW'(mism);

        if (!enable) begin
            state_n = IDLE;
            fill_n  = '0;
            vcnt_n  = '0;
            wcnt_n  = '0;
            werr_n  = '0;
        end else begin
            unique case (state)
                IDLE: state_n = SEED;
                SEED: if (din_valid) begin
                    sr_n = {sr[PRBS_W-2:0], din};
                    if (fill == FW'(PRBS_W - 1)) begin
                        fill_n = '0;
                        // An all-zero seed would lock onto a dead stream
                        if (sr_n != '0) state_n = VERIFY;
                    end else begin
                        fill_n = fill + FW'(1);
                    end
                end
                VERIFY: if (din_valid) begin
                    sr_n = {sr[PRBS_W-2:0], din};
                    if (mism) begin
                        state_n = SEED;
                        vcnt_n  = '0;
                    end else if (vcnt == VW'(VERIFY_LEN - 1)) begin
                        state_n = LOCKED;
                        vcnt_n  = '0;
                        wcnt_n  = '0;
                        werr_n  = '0;
                    end else begin
                        vcnt_n = vcnt + VW'(1);
                    end
                end
                LOCKED: if (din_valid) begin
                    // Track the prediction so one flipped bit is one error
                    sr_n    = {sr[PRBS_W-2:0], pred};
                    bit_inc = 1'b1;
                    err_inc = mism;
                    error_n = mism;
                    if (werr_inc == EW'(LOSS_THRESH)) begin
                        state_n = SEED;
                        fill_n  = '0;
                        wcnt_n  = '0;
                        werr_n  = '0;
                    end else if (wcnt == WW'(LOSS_WINDOW - 1)) begin
                        wcnt_n = '0;
                        werr_n = '0;
                    end else begin
                        wcnt_n = wcnt + WW'(1);
                        werr_n = werr_inc;
                    end
                end
            endcase
        end
    end

    assign locked = (state == LOCKED);

    sat_counter #(.WIDTH(CNT_W)) u_bits (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (bit_inc),
        .q       (bit_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_errs (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (err_inc),
        .q       (err_count)
    );

endmodule
